segment_chaser_pwm: RTL and testbench
=====================================

Name: segment_chaser_pwm

Overview:
Parametrised N-channel LED chaser with per-channel PWM brightness and exponential fading trail, for driving seven-segment or bar LED arrays directly from TinyTapeout-style pins. A step divider moves a lit position along the channel path. A fade divider halves every channel's brightness. A free-running PWM counter turns brightness into on/off outputs. Adds bounce, fill and hold modes, runtime fade enable and a position/step status output.

Parameters:
NUM_CH, 8, number of LED channels in path order 0..NUM_CH-1 (min 2)
PWM_BITS, 5, brightness resolution per channel; max brightness = 2^PWM_BITS-1
STEP_DIV_WIDTH, 22, step divider width; base step period = 2^(STEP_DIV_WIDTH-3) clocks
FADE_DIV_WIDTH, 20, fade tick every 2^FADE_DIV_WIDTH clocks
ACTIVE_LOW_OUT, 1, 1 = led_out inverted (common anode), 0 = active high

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  synchronous reset, active low
speed  input  3  step period select; period = (speed+1)*2^(STEP_DIV_WIDTH-3) clocks
dir  input  1  chase/fill direction: 1 = up (pos+1), 0 = down
mode  input  2  00 chase, 01 bounce, 10 fill, 11 hold
fade_en  input  1  1 = fade ticks applied in chase/bounce
led_out  output  NUM_CH  PWM'd channel drive, polarity per ACTIVE_LOW_OUT
pos  output  clog2(NUM_CH)  current lit position
step_pulse  output  1  one-cycle pulse on each position update

Behaviour:
- Reset (reset_n=0 at clk edge):
  - all brightness 0; pos=0; all counters 0; bounce direction = up; step_pulse=0.
  - led_out = all 1s if ACTIVE_LOW_OUT, else all 0s.
  - Reset mid-operation discards all state the same cycle.
- Input sync: speed, dir, mode and fade_en are registered once; all logic uses the registered copies, so there is 1 cycle of input latency.
- Step divider:
  - if step_cnt >= limit, then step_cnt<=0 and a step tick fires; else step_cnt+1.
  - limit = (speed_r+1)*2^(STEP_DIV_WIDTH-3)-1.
  - Lowering speed mid-period while step_cnt >= the new limit fires a tick on the next cycle.
- Step tick, by mode:
  - chase: dir_r=1 gives pos+1, wrapping NUM_CH-1 to 0. dir_r=0 gives pos-1, wrapping 0 to NUM_CH-1.
  - bounce: dir ignored; internal bdir.
    - pos moves per bdir.
    - At pos=NUM_CH-1 moving up, bdir flips and pos becomes NUM_CH-2.
    - At pos=0 moving down, bdir flips and pos becomes 1.
    - Entering bounce from any other mode sets bdir=up.
  - fill: pos moves as in chase. On wrap (pos returns to the start end), all channels are cleared and the new pos is set.
  - hold: no pos change, no step_pulse, no brightness change. The divider keeps counting.
- On a step tick in chase/bounce/fill, bright[new pos] <= max the same cycle pos updates. step_pulse is high that cycle (registered, aligned with the pos change).
- Fade:
  - Free-running fade_cnt; a tick fires when fade_cnt==0.
  - On a tick, if fade_en_r=1 and mode is chase or bounce, every bright[i] <= bright[i]>>1.
  - No fading in fill or hold.
  - Fade tick and step tick in the same cycle: the newly lit channel gets max (set wins); all others shift.
- PWM:
  - Free-running PWM_BITS counter pwm_cnt.
  - on[i] = bright[i] > pwm_cnt, registered into led_out (1-cycle latency), then inverted if ACTIVE_LOW_OUT.
  - Brightness max is on for 2^PWM_BITS-1 of every 2^PWM_BITS cycles; brightness 0 is never on.
- All arithmetic is unsigned. Counters wrap naturally at their width. pos never leaves 0..NUM_CH-1 for non-power-of-2 NUM_CH.

Test Plan:
All scenarios use NUM_CH=4, PWM_BITS=3, STEP_DIV_WIDTH=5 (period (speed+1)*4), FADE_DIV_WIDTH=4, ACTIVE_LOW_OUT=1.
1. Hold reset_n=0 for 3 clocks -> led_out=4'b1111, pos=0, step_pulse=0. Release with mode=00, dir=1, speed=0 -> step_pulse every 4 clocks; pos sequence 1,2,3,0,1.
2. Chase with dir=0, speed=1 -> pulses every 8 clocks; pos 3,2,1,0,3. Set fade_en=1 -> the lit channel is on 7/8 PWM cycles; its brightness after 1 fade tick is 3 (on 3/8) and after 3 ticks is 0.
3. Bounce from pos=0 with speed=0 -> pos 1,2,3,2,1,0,1; dir toggling has no effect.
4. Fill with dir=1 -> brightness at pos 0..3 reaches 7 and never fades. On the wrap to pos 0, channels 1-3 clear the same cycle and channel 0 becomes 7.
5. Hold mid-chase at pos=2 -> no step_pulse and pos stays 2 for 40 clocks; brightness stays frozen despite fade_en=1. Resume chase -> next step goes to pos 3.
6. Force a fade tick and a step tick in the same cycle (align by reset timing) -> new pos brightness=7, previous pos brightness halved. Then assert reset_n=0 mid-run -> led_out=4'b1111 on the next edge.

Source files
------------

// File: rtl/segment_chaser_pwm.sv
// ---------------------------------------------------------------------------
// segment_chaser_pwm
//
// N-channel LED chaser. A lit position moves along the channels and leaves a
// fading trail. Each channel has its own PWM brightness. The outputs drive
// seven-segment or bar LED arrays directly.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_reset_n      synchronous reset, active low
//   i_speed[2:0]   step period select: (speed+1) * 2^(STEP_DIV_WIDTH-3) clocks
//   i_dir          chase/fill direction, 1 = up (pos+1), 0 = down
//   i_mode[1:0]    00 chase, 01 bounce, 10 fill, 11 hold
//   i_fade_en      1 = fade ticks halve brightness in chase/bounce
//   o_led_out      PWM'd channel drive; inverted when ACTIVE_LOW_OUT = 1
//   o_pos          current lit position
//   o_step_pulse   one-cycle pulse, aligned with each position update
// ---------------------------------------------------------------------------
module segment_chaser_pwm #(
    parameter int NUM_CH         = 8,
    parameter int PWM_BITS       = 5,
    parameter int STEP_DIV_WIDTH = 22,
    parameter int FADE_DIV_WIDTH = 20,
    parameter int ACTIVE_LOW_OUT = 1
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic [2:0]                i_speed,
    input  logic                      i_dir,
    input  logic [1:0]                i_mode,
    input  logic                      i_fade_en,
    output logic [NUM_CH-1:0]         o_led_out,
    output logic [$clog2(NUM_CH)-1:0] o_pos,
    output logic                      o_step_pulse
);

    localparam int POS_W      = $clog2(NUM_CH);
    localparam int STEP_SHIFT = STEP_DIV_WIDTH - 3;

    localparam logic [PWM_BITS-1:0] BRIGHT_MAX = {PWM_BITS{1'b1}};
    localparam logic [POS_W-1:0]    POS_LAST   = POS_W'(NUM_CH - 1);
    localparam logic [POS_W-1:0]    POS_FIRST  = '0;
    localparam logic                OUT_INV    = (ACTIVE_LOW_OUT != 0);

    typedef enum logic [1:0] {
        MODE_CHASE  = 2'b00,
        MODE_BOUNCE = 2'b01,
        MODE_FILL   = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    // Registered copies of the control inputs
    logic [2:0]  r_speed;
    logic        r_dir;
    mode_e       r_mode;
    logic        r_fadeEn;

    // Dividers and PWM timebase
    logic [STEP_DIV_WIDTH-1:0] r_stepCnt;
    logic [FADE_DIV_WIDTH-1:0] r_fadeCnt;
    logic [PWM_BITS-1:0]       r_pwmCnt;

    // Chaser state
    logic [POS_W-1:0]    r_pos;
    logic                r_bdir;
    logic                r_stepPulse;
    logic [PWM_BITS-1:0] r_bright [NUM_CH];
    logic [NUM_CH-1:0]   r_ledOut;

    // Combinational helpers
    logic [STEP_DIV_WIDTH:0] w_periodLen;
    logic [STEP_DIV_WIDTH:0] w_stepLimit;
    logic                    w_stepTick;
    logic                    w_fadeTick;
    logic                    w_advance;
    logic                    w_fadeApply;
    logic [POS_W-1:0]        w_nextPos;
    logic                    w_nextBdir;
    logic                    w_wrap;
    logic [PWM_BITS-1:0]     w_brightNext [NUM_CH];
    logic [NUM_CH-1:0]       w_ledOn;

    // The step limit comes from the registered speed every cycle. A tick
    // fires as soon as the count reaches or passes the limit. So lowering the
    // speed mid-period, with the count already beyond the new limit, fires a
    // tick right away instead of waiting for the counter to wrap.
    always_comb begin
        w_periodLen = (STEP_DIV_WIDTH + 1)'({1'b0, r_speed} + 4'd1) << STEP_SHIFT;
        w_stepLimit = w_periodLen - (STEP_DIV_WIDTH + 1)'(1);
        w_stepTick  = ({1'b0, r_stepCnt} >= w_stepLimit);
        w_fadeTick  = (r_fadeCnt == '0);
        w_advance   = w_stepTick && (r_mode != MODE_HOLD);
        w_fadeApply = w_fadeTick && r_fadeEn &&
                      ((r_mode == MODE_CHASE) || (r_mode == MODE_BOUNCE));
    end

    // Next position for the coming step tick. Chase and fill wrap around
    // the ends, and a wrap in fill also restarts the bar. Bounce reflects off
    // each end, so the position after an end is its neighbour.
    always_comb begin
        w_nextPos  = r_pos;
        w_nextBdir = r_bdir;
        w_wrap     = 1'b0;
        case (r_mode)
            MODE_CHASE, MODE_FILL: begin
                if (r_dir) begin
                    if (r_pos == POS_LAST) begin
                        w_nextPos = POS_FIRST;
                        w_wrap    = 1'b1;
                    end else begin
                        w_nextPos = r_pos + POS_W'(1);
                    end
                end else begin
                    if (r_pos == POS_FIRST) begin
                        w_nextPos = POS_LAST;
                        w_wrap    = 1'b1;
                    end else begin
                        w_nextPos = r_pos - POS_W'(1);
                    end
                end
            end
            MODE_BOUNCE: begin
                if (r_bdir) begin
                    if (r_pos == POS_LAST) begin
                        w_nextBdir = 1'b0;
                        w_nextPos  = POS_LAST - POS_W'(1);
                    end else begin
                        w_nextPos = r_pos + POS_W'(1);
                    end
                end else begin
                    if (r_pos == POS_FIRST) begin
                        w_nextBdir = 1'b1;
                        w_nextPos  = POS_FIRST + POS_W'(1);
                    end else begin
                        w_nextPos = r_pos - POS_W'(1);
                    end
                end
            end
            default: begin
                w_nextPos = r_pos;
            end
        endcase
    end

    // Brightness update, lowest to highest priority: fade halves everything,
    // a fill wrap clears the bar, and the newly lit channel is forced to full.
    // This order lets the set win when a fade tick and a step tick land on
    // the same cycle.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_brightNext[i] = r_bright[i];
            if (w_fadeApply) begin
                w_brightNext[i] = r_bright[i] >> 1;
            end
            if (w_advance && (r_mode == MODE_FILL) && w_wrap) begin
                w_brightNext[i] = '0;
            end
            if (w_advance && (POS_W'(i) == w_nextPos)) begin
                w_brightNext[i] = BRIGHT_MAX;
            end
        end
    end

    // PWM compare. Maximum brightness is on for all but one count of the
    // period, and zero brightness is never on.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_ledOn[i] = (r_bright[i] > r_pwmCnt);
        end
    end

    // All state lives here. Outside bounce, the bounce direction is held at
    // "up". That way, entering bounce from any other mode starts upward,
    // even when the first step lands in the same cycle as the mode change.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_speed     <= '0;
            r_dir       <= 1'b0;
            r_mode      <= MODE_CHASE;
            r_fadeEn    <= 1'b0;
            r_stepCnt   <= '0;
            r_fadeCnt   <= '0;
            r_pwmCnt    <= '0;
            r_pos       <= '0;
            r_bdir      <= 1'b1;
            r_stepPulse <= 1'b0;
            r_ledOut    <= {NUM_CH{OUT_INV}};
            for (int i = 0; i < NUM_CH; i++) begin
                r_bright[i] <= '0;
            end
        end else begin
            r_speed  <= i_speed;
            r_dir    <= i_dir;
            r_mode   <= mode_e'(i_mode);
            r_fadeEn <= i_fade_en;

            if (w_stepTick) begin
                r_stepCnt <= '0;
            end else begin
                r_stepCnt <= r_stepCnt + STEP_DIV_WIDTH'(1);
            end
            r_fadeCnt <= r_fadeCnt + FADE_DIV_WIDTH'(1);
            r_pwmCnt  <= r_pwmCnt + PWM_BITS'(1);

            r_stepPulse <= w_advance;
            if (w_advance) begin
                r_pos <= w_nextPos;
            end

            if (r_mode != MODE_BOUNCE) begin
                r_bdir <= 1'b1;
            end else if (w_advance) begin
                r_bdir <= w_nextBdir;
            end

            for (int i = 0; i < NUM_CH; i++) begin
                r_bright[i] <= w_brightNext[i];
            end
            r_ledOut <= w_ledOn ^ {NUM_CH{OUT_INV}};
        end
    end

    assign o_led_out    = r_ledOut;
    assign o_pos        = r_pos;
    assign o_step_pulse = r_stepPulse;

endmodule

// File: tb/tb_segment_chaser_pwm.sv
// ---------------------------------------------------------------------------
// tb_segment_chaser_pwm
//
// Directed bench for segment_chaser_pwm. It uses NUM_CH=4, PWM_BITS=3,
// STEP_DIV_WIDTH=5 (step period (speed+1)*4), FADE_DIV_WIDTH=4 and
// active-low outputs.
//
// Each expected step (position, and clocks since the previous observation
// point) is pushed to a queue when its stimulus is set up. It is popped when
// the DUT raises o_step_pulse.
//
// Brightness is read back through the PWM outputs. Over any 8 consecutive
// clocks, a channel is driven low exactly "brightness" times.
// ---------------------------------------------------------------------------
module tb_segment_chaser_pwm;

    localparam int NUM_CH   = 4;
    localparam int PWM_PER  = 8;
    localparam int STEP_MAX = 64;

    logic       clk = 1'b0;
    logic       resetN;
    logic [2:0] speed;
    logic       dir;
    logic [1:0] mode;
    logic       fadeEn;
    logic [3:0] ledOut;
    logic [1:0] pos;
    logic       stepPulse;

    typedef struct {
        int pos;
        int gap;
    } stepExp_t;

    stepExp_t expQ[$];
    int errors = 0;
    int checks = 0;
    int onCnt [NUM_CH];

    segment_chaser_pwm #(
        .NUM_CH         (4),
        .PWM_BITS       (3),
        .STEP_DIV_WIDTH (5),
        .FADE_DIV_WIDTH (4),
        .ACTIVE_LOW_OUT (1)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (resetN),
        .i_speed      (speed),
        .i_dir        (dir),
        .i_mode       (mode),
        .i_fade_en    (fadeEn),
        .o_led_out    (ledOut),
        .o_pos        (pos),
        .o_step_pulse (stepPulse)
    );

    always #5 clk = ~clk;

    // Compare one observed value against the bench's expectation
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive all inputs; these are sampled by the DUT on the next rising edge
    task automatic applyStimulus(input logic rst, input logic [1:0] m, input logic d,
                                 input logic [2:0] s, input logic f);
        resetN = rst;
        mode   = m;
        dir    = d;
        speed  = s;
        fadeEn = f;
    endtask

    task automatic pushStep(input int p, input int g);
        stepExp_t e;
        e.pos = p;
        e.gap = g;
        expQ.push_back(e);
    endtask

    // Wait (bounded) for the next step pulse, then score it against the queue
    task automatic waitStep(input string tag);
        stepExp_t e;
        int       n;
        logic     seen;
        e.pos = -1;
        e.gap = -1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
        end
        n    = 0;
        seen = 1'b0;
        while (!seen && (n < STEP_MAX)) begin
            @(negedge clk);
            n++;
            if (stepPulse === 1'b1) begin
                seen = 1'b1;
            end
        end
        checkOutput({tag, "_seen"}, 32'(seen), 32'd1);
        checkOutput({tag, "_gap"}, 32'(n), 32'(e.gap));
        checkOutput({tag, "_pos"}, 32'(pos), 32'(e.pos));
    endtask

    // Hold reset for nClk edges, check the reset state, then release
    task automatic resetDut(input int nClk, input logic [1:0] m, input logic d,
                            input logic [2:0] s, input logic f);
        applyStimulus(1'b0, m, d, s, f);
        repeat (nClk) @(negedge clk);
        checkOutput("reset_led", 32'(ledOut), 32'hF);
        checkOutput("reset_pos", 32'(pos), 32'd0);
        checkOutput("reset_pulse", 32'(stepPulse), 32'd0);
        resetN = 1'b1;
    endtask

    // Count active-low on-cycles per channel over one PWM period
    task automatic checkPwm(input string tag, input int e0, input int e1,
                            input int e2, input int e3);
        int expv [NUM_CH];
        expv[0] = e0;
        expv[1] = e1;
        expv[2] = e2;
        expv[3] = e3;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            onCnt[ch] = 0;
        end
        repeat (PWM_PER) begin
            @(negedge clk);
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (ledOut[ch] === 1'b0) begin
                    onCnt[ch]++;
                end
            end
        end
        for (int ch = 0; ch < NUM_CH; ch++) begin
            checkOutput($sformatf("%s_ch%0d", tag, ch), 32'(onCnt[ch]), 32'(expv[ch]));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Directed sequence: chase up/down, hold, bounce, fill, fade decay,
    // coincident fade/step ticks and a final mid-run reset
    initial begin
        int badPulse;
        int badPos;
        badPulse = 0;
        badPos   = 0;

        $display("[TB] start");

        // Chase up at speed 0: a step every 4 clocks
        resetDut(3, 2'b00, 1'b1, 3'd0, 1'b0);
        pushStep(1, 4);
        pushStep(2, 4);
        pushStep(3, 4);
        pushStep(0, 4);
        pushStep(1, 4);
        for (int k = 0; k < 5; k++) begin
            waitStep($sformatf("chase_up%0d", k));
        end

        // Chase down at speed 1: a step every 8 clocks, with wrap 0 -> 3
        applyStimulus(1'b1, 2'b00, 1'b0, 3'd1, 1'b0);
        pushStep(0, 8);
        pushStep(3, 8);
        pushStep(2, 8);
        pushStep(1, 8);
        pushStep(0, 8);
        for (int k = 0; k < 5; k++) begin
            waitStep($sformatf("chase_dn%0d", k));
        end

        // Back up to position 2, then hold with fade enabled
        applyStimulus(1'b1, 2'b00, 1'b1, 3'd1, 1'b0);
        pushStep(1, 8);
        pushStep(2, 8);
        waitStep("pre_hold1");
        waitStep("pre_hold2");
        applyStimulus(1'b1, 2'b11, 1'b1, 3'd1, 1'b1);
        repeat (32) begin
            @(negedge clk);
            if (stepPulse !== 1'b0) badPulse++;
            if (pos !== 2'd2) badPos++;
        end
        checkOutput("hold_no_pulse", 32'(badPulse), 32'd0);
        checkOutput("hold_pos", 32'(badPos), 32'd0);
        checkPwm("hold_frozen", 7, 7, 7, 7);

        // Resume chase: the divider kept running, so the next step is 8 clocks out
        applyStimulus(1'b1, 2'b00, 1'b1, 3'd1, 1'b1);
        pushStep(3, 8);
        waitStep("resume");

        // Bounce from position 3 at speed 0; dir is toggled after every step
        applyStimulus(1'b1, 2'b01, 1'b1, 3'd0, 1'b1);
        pushStep(2, 4);
        pushStep(1, 4);
        pushStep(0, 4);
        pushStep(1, 4);
        pushStep(2, 4);
        pushStep(3, 4);
        pushStep(2, 4);
        for (int k = 0; k < 7; k++) begin
            waitStep($sformatf("bounce%0d", k));
            dir = ~dir;
        end

        // Fill upward at speed 3 (16 clocks per step)
        applyStimulus(1'b1, 2'b10, 1'b1, 3'd3, 1'b1);
        pushStep(3, 16);
        pushStep(0, 16);
        waitStep("fill3");
        waitStep("fill_wrap1");
        checkPwm("fill_cleared", 7, 0, 0, 0);
        pushStep(1, 8);
        pushStep(2, 16);
        pushStep(3, 16);
        waitStep("fill1");
        waitStep("fill2");
        waitStep("fill3b");
        checkPwm("fill_full", 7, 7, 7, 7);
        pushStep(0, 8);
        waitStep("fill_wrap2");
        checkPwm("fill_recleared", 7, 0, 0, 0);

        // Fade decay. Light channel 1 at clock 4, then slow the steps down.
        // Fade ticks at clocks 17/33/49 take it 7 -> 3 -> 1 -> 0.
        resetDut(1, 2'b00, 1'b1, 3'd0, 1'b1);
        pushStep(1, 4);
        waitStep("fade_step1");
        applyStimulus(1'b1, 2'b00, 1'b1, 3'd7, 1'b1);
        checkPwm("fade_lit", 0, 7, 0, 0);
        idle(7);
        checkPwm("fade_1tick", 0, 3, 0, 0);
        pushStep(2, 9);
        waitStep("fade_step2");
        checkPwm("fade_2tick", 0, 1, 7, 0);
        idle(7);
        checkPwm("fade_3tick", 0, 0, 3, 0);

        // Coincident ticks. Speed 2 steps at clock 12. Dropping to speed 0
        // with the count already past the new limit steps at clock 17, the
        // same clock as a fade tick. Hold then freezes the result.
        resetDut(1, 2'b00, 1'b1, 3'd2, 1'b1);
        pushStep(1, 12);
        waitStep("align_step1");
        idle(3);
        applyStimulus(1'b1, 2'b00, 1'b1, 3'd0, 1'b1);
        idle(1);
        applyStimulus(1'b1, 2'b11, 1'b1, 3'd0, 1'b1);
        pushStep(2, 1);
        waitStep("align_step2");
        checkPwm("align_bright", 0, 3, 7, 0);

        // Reset in the middle of a run takes effect on the next edge
        resetDut(1, 2'b00, 1'b1, 3'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
